// File: rtl/mii_frame_arbiter_if.sv
// Request/TX-lane bundle of mii_frame_arbiter: master = frame sources and lane sink, slave = arbiter.
// Statistics signals are present only when MII_ARB_STATS_EN is defined.
interface mii_frame_arbiter_if #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    localparam int ID_W = $clog2(N_SRC);

    logic [N_SRC-1:0]            req_valid;
    logic [N_SRC*DATA_WIDTH-1:0] req_data;
    logic [N_SRC*CTRL_WIDTH-1:0] req_ctrl;
    logic [N_SRC-1:0]            req_last;
    logic [N_SRC-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]       tx_data;
    logic [CTRL_WIDTH-1:0]       tx_ctrl;
    logic [ID_W-1:0]             grant_id;
    logic                        busy;
    logic                        underrun;
`ifdef MII_ARB_STATS_EN
    logic [N_SRC*16-1:0]         frame_cnt;
    logic [15:0]                 underrun_cnt;
`endif

    modport master (
        output req_valid, req_data, req_ctrl, req_last,
`ifdef MII_ARB_STATS_EN
        input  frame_cnt, underrun_cnt,
`endif
        input  req_ready, tx_data, tx_ctrl, grant_id, busy, underrun
    );

    modport slave (
        input  req_valid, req_data, req_ctrl, req_last,
`ifdef MII_ARB_STATS_EN
        output frame_cnt, underrun_cnt,
`endif
        output req_ready, tx_data, tx_ctrl, grant_id, busy, underrun
    );
endinterface

// File: rtl/mii_frame_arbiter.sv
// Round-robin whole-frame arbiter of N MAC sources onto one MII TX lane; MII_ARB_STATS_EN adds counters.
// Latency 1 (accepted beat on lane next cycle); only the granted source sees ready, bubbles emit error beats.
module mii_frame_arbiter #(
    parameter int         N_SRC      = 4,
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter int         IFG_BEATS  = 2,
    parameter logic [7:0] IDLE_CODE  = 8'h07,
    parameter logic [7:0] ERROR_CODE = 8'hFE
) (
    input  logic               clk,
    input  logic               i_rst_n,
    mii_frame_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_SRC);
    localparam int IFG_W = (IFG_BEATS > 0) ? $clog2(IFG_BEATS + 1) : 1;
    localparam logic [DATA_WIDTH-1:0] IDLE_DAT = {CTRL_WIDTH{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] ERR_DAT  = {CTRL_WIDTH{ERROR_CODE}};

    if (N_SRC < 2 || N_SRC > 8 || DATA_WIDTH != 8 * CTRL_WIDTH) begin : g_bad_cfg
        $error("mii_frame_arbiter: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_XFER = 2'd1,
        ST_IFG  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [IFG_W-1:0]      ifg_q, ifg_d;
    logic [DATA_WIDTH-1:0] tx_dat_q, tx_dat_d;
    logic [CTRL_WIDTH-1:0] tx_ctl_q, tx_ctl_d;
    logic                  underrun_q, underrun_d;

    logic                  pick_vld;
    logic [ID_W-1:0]       pick_id;
    logic [ID_W-1:0]       cand_id;
    logic [ID_W-1:0]       next_ptr;
    logic                  gnt_vld;
    logic                  gnt_last;
    logic [DATA_WIDTH-1:0] gnt_dat;
    logic [CTRL_WIDTH-1:0] gnt_ctl;
    logic [N_SRC-1:0]      ready;
    logic                  frame_done;
    logic                  bubble;

    // rr_q holds the first index to search, i.e. last winner + 1
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand_id  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand_id = ID_W'((int'(rr_q) + i) % N_SRC);
            if (!pick_vld && bus.req_valid[cand_id]) begin
                pick_vld = 1'b1;
                pick_id  = cand_id;
            end
        end
    end

    // Only the owner's request signals are ever looked at
    assign gnt_vld    = bus.req_valid[grant_q];
    assign gnt_last   = bus.req_last[grant_q];
    assign gnt_dat    = bus.req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    assign gnt_ctl    = bus.req_ctrl[int'(grant_q) * CTRL_WIDTH +: CTRL_WIDTH];
    assign next_ptr   = ID_W'((int'(grant_q) + 1) % N_SRC);
    assign frame_done = (state_q == ST_XFER) && gnt_vld && gnt_last;
    assign bubble     = (state_q == ST_XFER) && !gnt_vld;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        ifg_d      = ifg_q;
        tx_dat_d   = IDLE_DAT;
        tx_ctl_d   = '1;
        underrun_d = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (pick_vld) begin
                    state_d = ST_XFER;
                    grant_d = pick_id;
                end
            end
            ST_XFER: begin
                if (gnt_vld) begin
                    tx_dat_d = gnt_dat;
                    tx_ctl_d = gnt_ctl;
                    if (gnt_last) begin
                        rr_d = next_ptr;
                        if (IFG_BEATS == 0) begin
                            state_d = ST_ARB;
                        end else begin
                            state_d = ST_IFG;
                            ifg_d   = IFG_W'(IFG_BEATS);
                        end
                    end
                end else begin
                    tx_dat_d   = ERR_DAT;
                    underrun_d = 1'b1;
                end
            end
            ST_IFG: begin
                ifg_d = ifg_q - IFG_W'(1);
                if (ifg_q <= IFG_W'(1)) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_ARB;
            grant_q    <= '0;
            rr_q       <= '0;
            ifg_q      <= '0;
            tx_dat_q   <= IDLE_DAT;
            tx_ctl_q   <= '1;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            ifg_q      <= ifg_d;
            tx_dat_q   <= tx_dat_d;
            tx_ctl_q   <= tx_ctl_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == ST_XFER) begin
            ready[grant_q] = 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_data   = tx_dat_q;
    assign bus.tx_ctrl   = tx_ctl_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q == ST_XFER);
    assign bus.underrun  = underrun_q;

`ifdef MII_ARB_STATS_EN
    logic [N_SRC*16-1:0] frame_cnt_q;
    logic [15:0]         urun_cnt_q;

    // Frame counters wrap; the underrun counter sticks at all-ones
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
            urun_cnt_q  <= '0;
        end else begin
            if (frame_done) begin
                frame_cnt_q[int'(grant_q) * 16 +: 16] <= frame_cnt_q[int'(grant_q) * 16 +: 16] + 16'd1;
            end
            if (bubble && (urun_cnt_q != 16'hFFFF)) begin
                urun_cnt_q <= urun_cnt_q + 16'd1;
            end
        end
    end

    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.underrun_cnt = urun_cnt_q;
`endif
endmodule
